// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator call panel and its controller.
// Holds the floor constants, the controller's direction encoding and the
// request-FSM state type. The CALL_CANCEL_EN build macro is consumed by
// elevator_call_panel, not here.
package elevator_pkg;

    localparam int unsigned NUM_FLOORS = 4;
    localparam int unsigned NUM_BUTTONS = 10;

    localparam logic [1:0] FLOOR1 = 2'd0;
    localparam logic [1:0] FLOOR2 = 2'd1;
    localparam logic [1:0] FLOOR3 = 2'd2;
    localparam logic [1:0] FLOOR4 = 2'd3;

    // Matches the controller's travel-direction encoding 0/1/2.
    typedef enum logic [1:0] {
        DirIdle = 2'd0,
        DirUp   = 2'd1,
        DirDown = 2'd2
    } dir_e;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StOffer  = 2'd1,
        StLocked = 2'd2
    } req_state_e;

endpackage

// File: rtl/button_debounce.sv
// Single-button debouncer with a one-shot press output.
// Ports:
//   clk    - system clock
//   reset  - asynchronous active-high reset
//   btn    - raw button input
//   press  - high for exactly one cycle: the cycle whose rising edge brings
//            the run of high samples up to DEB_CYCLES
module button_debounce #(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(DEB_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    // Saturates at DEB_CYCLES so a held button never re-arms the one-shot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (!btn) begin
            cnt_q <= '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Combinational so the lamp latches on the same edge the count reaches DEB_CYCLES.
    assign press = btn && (cnt_q == CNT_ARM);

endmodule

// File: rtl/elevator_call_panel.sv
// Elevator call panel: debounces the car and hall buttons, latches calls,
// drives the lamps and offers one target floor at a time to the controller
// over a valid/ack handshake.
// Build option: CALL_CANCEL_EN - a press on a lit car button cancels that call.
// Ports:
//   clk, reset                    - clock, asynchronous active-high reset
//   F1..F4                        - raw car buttons, floors 0..3
//   F1up..F3up, F2down..F4down    - raw hall buttons
//   floor, up, down, door_open    - controller status
//   req_ack                       - controller accepts req_floor (pulse)
//   car_lamp, hall_up_lamp, hall_dn_lamp - pending calls (hall_dn bit i = floor i+1)
//   req_valid, req_floor, req_locked     - target offer to the controller
module elevator_call_panel
    import elevator_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       F1,
    input  logic       F2,
    input  logic       F3,
    input  logic       F4,
    input  logic       F1up,
    input  logic       F2up,
    input  logic       F3up,
    input  logic       F2down,
    input  logic       F3down,
    input  logic       F4down,
    input  logic [1:0] floor,
    input  logic       up,
    input  logic       down,
    input  logic       door_open,
    input  logic       req_ack,
    output logic [3:0] car_lamp,
    output logic [2:0] hall_up_lamp,
    output logic [2:0] hall_dn_lamp,
    output logic       req_valid,
    output logic [1:0] req_floor,
    output logic       req_locked
);

    logic [NUM_BUTTONS-1:0] raw;
    logic [NUM_BUTTONS-1:0] press;

    // Bits 0..3 car, 4..6 hall-up floors 0..2, 7..9 hall-down floors 1..3.
    assign raw = {F4down, F3down, F2down, F3up, F2up, F1up, F4, F3, F2, F1};

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_deb
        button_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk  (clk),
            .reset(reset),
            .btn  (raw[i]),
            .press(press[i])
        );
    end

    // Lamp next-state: set (or toggle) on press, service clear has priority.
    logic [3:0] at_floor;
    logic [3:0] car_d;
    logic [2:0] hu_d;
    logic [2:0] hd_d;

    always_comb begin
        at_floor = door_open ? (4'b0001 << floor) : 4'b0000;
`ifdef CALL_CANCEL_EN
        car_d = (car_lamp ^ press[3:0]) & ~at_floor;
`else
        car_d = (car_lamp | press[3:0]) & ~at_floor;
`endif
        hu_d = (hall_up_lamp | press[6:4]) & ~(down ? 3'b000 : at_floor[2:0]);
        hd_d = (hall_dn_lamp | press[9:7]) & ~(up ? 3'b000 : at_floor[3:1]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            car_lamp     <= '0;
            hall_up_lamp <= '0;
            hall_dn_lamp <= '0;
        end else begin
            car_lamp     <= car_d;
            hall_up_lamp <= hu_d;
            hall_dn_lamp <= hd_d;
        end
    end

    // Target selection over the pending vector.
    logic [3:0] pending;
    logic       has_above;
    logic       has_below;
    logic [1:0] above;
    logic [1:0] below;
    logic [1:0] target;
    logic       reverse;
    logic       sweep_up;

    assign pending = car_lamp | {hall_dn_lamp, 1'b0} | {1'b0, hall_up_lamp};

    always_comb begin
        has_above = 1'b0;
        has_below = 1'b0;
        above     = 2'd0;
        below     = 2'd0;
        // Descending scan leaves the lowest floor above; ascending scan the highest below.
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (i > int'(floor))) begin
                has_above = 1'b1;
                above     = 2'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (i < int'(floor))) begin
                has_below = 1'b1;
                below     = 2'(i);
            end
        end
        target  = floor;
        reverse = 1'b0;
        if (sweep_up) begin
            if (has_above) begin
                target = above;
            end else if (has_below) begin
                target  = below;
                reverse = 1'b1;
            end
        end else begin
            if (has_below) begin
                target = below;
            end else if (has_above) begin
                target  = above;
                reverse = 1'b1;
            end
        end
    end

    req_state_e state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            req_valid  <= 1'b0;
            req_floor  <= 2'd0;
            req_locked <= 1'b0;
            sweep_up   <= 1'b1;
        end else begin
            case (state)
                StIdle: begin
                    if (|pending) begin
                        state     <= StOffer;
                        req_valid <= 1'b1;
                        req_floor <= target;
                        if (reverse) sweep_up <= ~sweep_up;
                    end
                end
                StOffer: begin
                    if (req_ack) begin
                        state      <= StLocked;
                        req_locked <= 1'b1;
                    end else if (pending == 4'b0000) begin
                        state     <= StIdle;
                        req_valid <= 1'b0;
                    end else begin
                        req_floor <= target;
                        if (reverse) sweep_up <= ~sweep_up;
                    end
                end
                StLocked: begin
                    // Release only on arrival, even if the call was already cleared.
                    if (door_open && (floor == req_floor)) begin
                        state      <= StIdle;
                        req_valid  <= 1'b0;
                        req_locked <= 1'b0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_call_panel.sv
module tb_elevator_call_panel;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] raw;
    logic [1:0] floor_in;
    logic       up_in, down_in, door_in, ack_in;
    logic [3:0] car_lamp;
    logic [2:0] hall_up_lamp, hall_dn_lamp;
    logic       req_valid, req_locked;
    logic [1:0] req_floor;

    always #5 clk = ~clk;

    elevator_call_panel #(
        .DEB_CYCLES(DEB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .F1          (raw[0]),
        .F2          (raw[1]),
        .F3          (raw[2]),
        .F4          (raw[3]),
        .F1up        (raw[4]),
        .F2up        (raw[5]),
        .F3up        (raw[6]),
        .F2down      (raw[7]),
        .F3down      (raw[8]),
        .F4down      (raw[9]),
        .floor       (floor_in),
        .up          (up_in),
        .down        (down_in),
        .door_open   (door_in),
        .req_ack     (ack_in),
        .car_lamp    (car_lamp),
        .hall_up_lamp(hall_up_lamp),
        .hall_dn_lamp(hall_dn_lamp),
        .req_valid   (req_valid),
        .req_floor   (req_floor),
        .req_locked  (req_locked)
    );

    // Reference model: run length of high samples per button, call flags,
    // and the offer state (0 idle, 1 offering, 2 locked).
    int run[10];
    bit lamp[10];
    int m_state, m_floor;
    bit m_valid, m_locked, m_sweep;
    int n_run[10];
    bit n_lamp[10];
    int n_state, n_floor;
    bit n_valid, n_locked, n_sweep;

    int n_pass = 0;
    int n_checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    function automatic int floor_of(input int b);
        if (b < 4) return b;
        else if (b < 7) return b - 4;
        else return b - 6;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 10; b++) begin
            run[b]  = 0;
            lamp[b] = 1'b0;
        end
        m_state  = 0;
        m_floor  = 0;
        m_valid  = 1'b0;
        m_locked = 1'b0;
        m_sweep  = 1'b1;
    endtask

    task automatic model_step();
        bit p[4];
        bit any;
        int fl, na, nb, tgt;
        bit rev, pr, nv;
        fl = int'(floor_in);
        any = 1'b0;
        for (int f = 0; f < 4; f++) p[f] = 1'b0;
        for (int b = 0; b < 10; b++) if (lamp[b]) p[floor_of(b)] = 1'b1;
        for (int f = 0; f < 4; f++) any |= p[f];
        // Nearest pending floor in each direction by distance.
        na = -1;
        nb = -1;
        for (int d = 1; d <= 3; d++) begin
            if (na < 0 && fl + d <= 3 && p[fl+d]) na = fl + d;
            if (nb < 0 && fl - d >= 0 && p[fl-d]) nb = fl - d;
        end
        tgt = fl;
        rev = 1'b0;
        if (m_sweep) begin
            if (na >= 0) tgt = na;
            else if (nb >= 0) begin tgt = nb; rev = 1'b1; end
        end else begin
            if (nb >= 0) tgt = nb;
            else if (na >= 0) begin tgt = na; rev = 1'b1; end
        end
        for (int b = 0; b < 10; b++) begin
            pr = raw[b] && (run[b] + 1 == DEB);
            nv = lamp[b];
            if (pr) begin
`ifdef CALL_CANCEL_EN
                nv = (b < 4) ? !lamp[b] : 1'b1;
`else
                nv = 1'b1;
`endif
            end
            if (door_in && fl == floor_of(b) &&
                (b < 4 || (b < 7 && !down_in) || (b >= 7 && !up_in))) nv = 1'b0;
            n_lamp[b] = nv;
            n_run[b] = raw[b] ? ((run[b] >= DEB) ? DEB : run[b] + 1) : 0;
        end
        n_state  = m_state;
        n_floor  = m_floor;
        n_valid  = m_valid;
        n_locked = m_locked;
        n_sweep  = m_sweep;
        if (m_state == 0) begin
            if (any) begin
                n_state = 1;
                n_valid = 1'b1;
                n_floor = tgt;
                if (rev) n_sweep = !m_sweep;
            end
        end else if (m_state == 1) begin
            if (ack_in) begin
                n_state  = 2;
                n_locked = 1'b1;
            end else if (!any) begin
                n_state = 0;
                n_valid = 1'b0;
            end else begin
                n_floor = tgt;
                if (rev) n_sweep = !m_sweep;
            end
        end else begin
            if (door_in && fl == m_floor) begin
                n_state  = 0;
                n_valid  = 1'b0;
                n_locked = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        check_eq("car_lamp", 32'(car_lamp), 32'({lamp[3], lamp[2], lamp[1], lamp[0]}));
        check_eq("hall_up_lamp", 32'(hall_up_lamp), 32'({lamp[6], lamp[5], lamp[4]}));
        check_eq("hall_dn_lamp", 32'(hall_dn_lamp), 32'({lamp[9], lamp[8], lamp[7]}));
        check_eq("req_valid", 32'(req_valid), 32'(m_valid));
        check_eq("req_floor", 32'(req_floor), 32'(m_floor));
        check_eq("req_locked", 32'(req_locked), 32'(m_locked));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        for (int b = 0; b < 10; b++) begin
            run[b]  = n_run[b];
            lamp[b] = n_lamp[b];
        end
        m_state  = n_state;
        m_floor  = n_floor;
        m_valid  = n_valid;
        m_locked = n_locked;
        m_sweep  = n_sweep;
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int dir;
        raw      = '0;
        floor_in = 2'd0;
        up_in    = 1'b0;
        down_in  = 1'b0;
        door_in  = 1'b0;
        ack_in   = 1'b0;
        reset    = 1'b1;
        model_reset();
        #12;
        compare_all();
        reset = 1'b0;

        // Debounce: 3-cycle glitch ignored, 4-cycle press latches F3.
        raw[2] = 1'b1;
        ticks(3);
        check_eq("deb_short", 32'(car_lamp), 32'd0);
        raw[2] = 1'b0;
        tick();
        raw[2] = 1'b1;
        ticks(4);
        check_eq("deb_press", 32'(car_lamp), 32'b0100);
        raw[2] = 1'b0;
        tick();
        check_eq("first_offer", 32'(req_floor), 32'd2);

        // Sweep up from floor 0: F4 then F2up, nearest above wins.
        raw[3] = 1'b1;
        ticks(4);
        raw[3] = 1'b0;
        raw[5] = 1'b1;
        ticks(4);
        raw[5] = 1'b0;
        tick();
        check_eq("sweep_near", 32'(req_floor), 32'd1);
        ack_in = 1'b1;
        tick();
        ack_in = 1'b0;
        check_eq("locked", 32'(req_locked), 32'd1);
        ticks(2);
        check_eq("locked_hold", 32'(req_floor), 32'd1);
        floor_in = 2'd1;
        door_in  = 1'b1;
        tick();
        door_in = 1'b0;
        check_eq("hall_up_clear", 32'(hall_up_lamp), 32'd0);
        check_eq("lock_release", 32'(req_valid), 32'd0);
        tick();
        check_eq("reoffer", 32'(req_floor), 32'd2);

        // Randomized traffic against the model, with one asynchronous reset mid-run.
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 10; b++) if ($urandom % 8 == 0) raw[b] = ~raw[b];
            if ($urandom % 5 == 0) floor_in = 2'($urandom % 4);
            dir     = int'($urandom % 3);
            up_in   = (dir == 1);
            down_in = (dir == 2);
            door_in = ($urandom % 4 == 0);
            ack_in  = ($urandom % 3 == 0);
            tick();
            if (i == 1500) begin
                raw   = '0;
                reset = 1'b1;
                #1;
                model_reset();
                compare_all();
                #2;
                reset = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
